// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Upstream half of the instruction fetch path. Holds the program counter,
// drives the program ROM address and alternates between a FETCH phase, which
// strobes the fetch register, and an EXECUTE phase, which strobes the
// datapath and accepts jump/halt requests from decode/control. A HALTED
// state parks the sequencer until resume is seen.
//
// Parameters
//   ADDR_W    PC / ROM address width in bits
//   RESET_PC  PC value loaded on reset (must fit in ADDR_W bits)
//
// Ports
//   clk        in   system clock, all state changes on the rising edge
//   reset      in   asynchronous active-low reset
//   enable     in   global run qualifier, 0 freezes PC, state and strobes
//   jump       in   PC load request, sampled only in EXECUTE
//   jump_addr  in   PC target when a jump is taken
//   halt       in   halt request, sampled only in EXECUTE
//   resume     in   leave HALTED, sampled only in HALTED
//   pc_out     out  current PC, wired to the program ROM address
//   fetch_en   out  fetch register enable (FETCH and enable)
//   exec_en    out  execute strobe (EXECUTE and enable)
//   phase      out  0 = FETCH, 1 = EXECUTE or HALTED
//   halted     out  1 while in HALTED
//   state_dbg  out  raw registered state encoding, for observation only
//
// Handshake: there is no valid/ready pairing here. jump, halt and resume are
// level requests consumed on the rising edge of a cycle in which the
// sequencer is in the state that samples them and enable is 1; in any other
// cycle they are ignored and not remembered.
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int ADDR_W   = 12,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc_out,
  output logic              fetch_en,
  output logic              exec_en,
  output logic              phase,
  output logic              halted,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'b00,
    ST_EXECUTE = 2'b01,
    ST_HALTED  = 2'b10
  } state_e;

  localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_ONE     = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  // -------------------------------------------------------------------------
  // State and PC registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC_V;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-PC logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_FETCH: begin
        // The fetch register captures ROM[pc_q] on this same edge, so the PC
        // may advance now; the addition wraps naturally at 2^ADDR_W.
        if (enable) begin
          pc_d    = pc_q + PC_ONE;
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        // jump and halt are independent: both together load the target and
        // park, so resume fetches from the jump target.
        if (enable) begin
          if (jump) begin
            pc_d = jump_addr;
          end
          state_d = halt ? ST_HALTED : ST_FETCH;
        end
      end
      ST_HALTED: begin
        if (enable && resume) begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        // Unused encoding: recover to FETCH on the next edge even if the
        // block is frozen, so a corrupted state cannot persist.
        state_d = ST_FETCH;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Moore outputs, gated by enable where the strobe must freeze
  // -------------------------------------------------------------------------
  always_comb begin
    pc_out    = pc_q;
    fetch_en  = (state_q == ST_FETCH) && enable;
    exec_en   = (state_q == ST_EXECUTE) && enable;
    phase     = (state_q != ST_FETCH);
    halted    = (state_q == ST_HALTED);
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam int ADDR_W = 12;

  localparam logic [1:0] S_FETCH   = 2'b00;
  localparam logic [1:0] S_EXECUTE = 2'b01;
  localparam logic [1:0] S_HALTED  = 2'b10;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              jump;
  logic [ADDR_W-1:0] jump_addr;
  logic              halt;
  logic              resume;
  logic [ADDR_W-1:0] pc_out;
  logic              fetch_en;
  logic              exec_en;
  logic              phase;
  logic              halted;
  logic [1:0]        state_dbg;

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .jump      (jump),
    .jump_addr (jump_addr),
    .halt      (halt),
    .resume    (resume),
    .pc_out    (pc_out),
    .fetch_en  (fetch_en),
    .exec_en   (exec_en),
    .phase     (phase),
    .halted    (halted),
    .state_dbg (state_dbg)
  );

  // -------------------------------------------------------------------------
  // Scoreboard counters and checkers
  // -------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks every output against hand-computed values in one go.
  task automatic check_all(input string tag, input logic [ADDR_W-1:0] e_pc,
                           input logic e_fe, input logic e_ee, input logic e_ph,
                           input logic e_h, input logic [1:0] e_st);
    check({tag, ".pc"},     32'(pc_out),    32'(e_pc));
    check({tag, ".fetch"},  32'(fetch_en),  32'(e_fe));
    check({tag, ".exec"},   32'(exec_en),   32'(e_ee));
    check({tag, ".phase"},  32'(phase),     32'(e_ph));
    check({tag, ".halted"}, 32'(halted),    32'(e_h));
    check({tag, ".state"},  32'(state_dbg), 32'(e_st));
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the
  // rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Directed stimulus
  // -------------------------------------------------------------------------
  initial begin
    reset     = 1'b0;
    enable    = 1'b1;
    jump      = 1'b0;
    jump_addr = '0;
    halt      = 1'b0;
    resume    = 1'b0;

    // Reset held for 3 cycles: FETCH at PC 0, fetch_en follows enable.
    #1;
    check_all("rst0", 12'h000, 1, 0, 0, 0, S_FETCH);
    step(); step(); step();
    check_all("rst3", 12'h000, 1, 0, 0, 0, S_FETCH);
    reset = 1'b1;

    // Steady run: pc 0,1,1,2,2,3 with alternating strobes.
    check_all("run0", 12'h000, 1, 0, 0, 0, S_FETCH);
    step(); check_all("run1", 12'h001, 0, 1, 1, 0, S_EXECUTE);
    step(); check_all("run2", 12'h001, 1, 0, 0, 0, S_FETCH);
    step(); check_all("run3", 12'h002, 0, 1, 1, 0, S_EXECUTE);
    step(); check_all("run4", 12'h002, 1, 0, 0, 0, S_FETCH);
    step(); check_all("run5", 12'h003, 0, 1, 1, 0, S_EXECUTE);

    // halt and resume outside their sampling states have no effect.
    step(); check_all("run6", 12'h003, 1, 0, 0, 0, S_FETCH);
    halt = 1'b1; resume = 1'b1;
    step(); check_all("fetch_ign", 12'h004, 0, 1, 1, 0, S_EXECUTE);
    halt = 1'b0;
    step(); check_all("resume_ign", 12'h004, 1, 0, 0, 0, S_FETCH);
    resume = 1'b0;
    step(); check_all("pc5", 12'h005, 0, 1, 1, 0, S_EXECUTE);

    // Jump at PC 5 in EXECUTE to 0x3A0.
    jump = 1'b1; jump_addr = 12'h3A0;
    step(); check_all("jmp_f", 12'h3A0, 1, 0, 0, 0, S_FETCH);
    jump = 1'b0;
    step(); check_all("jmp_e", 12'h3A1, 0, 1, 1, 0, S_EXECUTE);

    // Simultaneous halt and jump to 0x010.
    halt = 1'b1; jump = 1'b1; jump_addr = 12'h010;
    step(); check_all("hj", 12'h010, 0, 0, 1, 1, S_HALTED);
    halt = 1'b0; jump_addr = 12'h055;
    for (int i = 0; i < 4; i++) begin
      step(); check_all($sformatf("hold%0d", i), 12'h010, 0, 0, 1, 1, S_HALTED);
    end
    jump = 1'b0; resume = 1'b1;
    step(); check_all("resume", 12'h010, 1, 0, 0, 0, S_FETCH);
    resume = 1'b0;
    step(); check_all("res_e", 12'h011, 0, 1, 1, 0, S_EXECUTE);

    // Wrap: load 0xFFF, fetch wraps PC to 0.
    jump = 1'b1; jump_addr = 12'hFFF;
    step(); check_all("wrap_f", 12'hFFF, 1, 0, 0, 0, S_FETCH);
    jump = 1'b0;
    step(); check_all("wrap_e", 12'h000, 0, 1, 1, 0, S_EXECUTE);

    // Freeze mid-EXECUTE for 3 cycles; requests during freeze are dropped.
    enable = 1'b0; jump = 1'b1; jump_addr = 12'h777; halt = 1'b1;
    #1;
    check_all("frz_now", 12'h000, 0, 0, 1, 0, S_EXECUTE);
    for (int i = 0; i < 3; i++) begin
      step(); check_all($sformatf("frz%0d", i), 12'h000, 0, 0, 1, 0, S_EXECUTE);
    end
    jump = 1'b0; halt = 1'b0; enable = 1'b1;
    step(); check_all("unfrz_f", 12'h000, 1, 0, 0, 0, S_FETCH);
    step(); check_all("unfrz_e", 12'h001, 0, 1, 1, 0, S_EXECUTE);

    // Reach EXECUTE at 0x123, then reset asynchronously between edges.
    jump = 1'b1; jump_addr = 12'h122;
    step(); check_all("pre_f", 12'h122, 1, 0, 0, 0, S_FETCH);
    jump = 1'b0;
    step(); check_all("pre_e", 12'h123, 0, 1, 1, 0, S_EXECUTE);
    #2;
    reset = 1'b0;
    #1;
    check_all("arst", 12'h000, 1, 0, 0, 0, S_FETCH);
    step();
    reset = 1'b1;
    check_all("arst_rel", 12'h000, 1, 0, 0, 0, S_FETCH);
    step(); check_all("arst_run", 12'h001, 0, 1, 1, 0, S_EXECUTE);

    // Async reset while HALTED.
    halt = 1'b1;
    step(); check_all("h2", 12'h001, 0, 0, 1, 1, S_HALTED);
    halt = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_all("arst_h", 12'h000, 1, 0, 0, 0, S_FETCH);
    step();
    reset = 1'b1;
    step(); check_all("arst_h_run", 12'h001, 0, 1, 1, 0, S_EXECUTE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Issues program-memory addresses and strobes the instruction fetch register, and is the upstream half of the fetch path. It holds the program counter (PC), drives the ROM address, and alternates between FETCH and EXECUTE phases. In FETCH it asserts the fetch-register enable so the ROM byte is latched as instruction/operand. In EXECUTE it accepts jump and halt requests from the decode/control logic.

## Interface
Parameters:
- ADDR_W, 12, PC/ROM address width in bits.
- RESET_PC, 0, PC value loaded on reset; must fit in ADDR_W bits.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset. Asserting it (0) clears state immediately. Release is sampled on clk.
- enable  input  1  global run qualifier; 0 freezes PC, state and all strobes.
- jump  input  1  load request; sampled only in EXECUTE with enable=1.
- jump_addr  input  ADDR_W  PC target when jump is taken.
- halt  input  1  halt request; sampled only in EXECUTE with enable=1.
- resume  input  1  exit HALTED; sampled only in HALTED with enable=1.
- pc_out  output  ADDR_W  current PC, wired to program ROM address.
- fetch_en  output  1  enable for the fetch register.
- exec_en  output  1  strobe telling the datapath to execute the latched instruction.
- phase  output  1  0 = FETCH, 1 = EXECUTE/HALTED.
- halted  output  1  1 while in HALTED.

## Operation
- States: FETCH, EXECUTE, HALTED; two-bit registered state, no other states reachable. Illegal encodings return to FETCH on next edge.
- Reset (reset=0): state=FETCH, pc_out=RESET_PC, halted=0, phase=0. fetch_en follows enable, exec_en=0.
- All outputs are Moore functions of registered state/PC, plus gating by the enable input:
  - fetch_en = (state==FETCH) & enable
  - exec_en = (state==EXECUTE) & enable
  - phase = (state!=FETCH)
  - halted = (state==HALTED)
- FETCH, enable=1: on the edge, the fetch register captures ROM[pc_out], pc_out <= pc_out+1, and state <= EXECUTE.
- EXECUTE, enable=1, the following hold on the edge:
  - jump=1: pc_out <= jump_addr; otherwise PC holds.
  - halt=1: state <= HALTED; otherwise state <= FETCH.
  - jump and halt both 1: PC loads jump_addr and state goes to HALTED. Resume then fetches from jump_addr.
- HALTED, enable=1: resume=1 gives state <= FETCH; otherwise the block stays in HALTED. PC holds. jump and halt are ignored.
- enable=0, any state: no state or PC change; fetch_en=exec_en=0. Inputs jump/halt/resume are ignored that cycle, not queued.
- PC arithmetic is modulo 2^ADDR_W: increment from all-ones wraps to 0 with no flag. jump_addr is taken verbatim.
- jump, halt and resume asserted outside their sampling state have no effect.

## Timing
- Steady run (enable=1, no jump/halt): one instruction per 2 cycles. fetch_en and exec_en alternate, and pc_out advances by 1 every 2 cycles.
- ROM read is combinational on pc_out. The byte presented during a FETCH cycle is captured on that cycle's rising edge.
- Jump latency: a jump in EXECUTE cycle N makes pc_out=jump_addr in cycle N+1 (FETCH). The target byte is latched at the end of cycle N+1.
- Halt latency: halted=1 in the cycle after the EXECUTE that sampled halt.
- Resume latency: FETCH (fetch_en=1) in the cycle after resume is sampled.
- Reset is asynchronous: outputs reach their reset values without a clock edge, including mid-EXECUTE or in HALTED. The first fetch after release is at RESET_PC on the first enabled edge.

## Test plan
- Reset/run: hold reset=0 for 3 cycles, release with enable=1 and RESET_PC=0 → pc_out sequence 0,1,1,2,2,3. fetch_en is 1 on cycles 0,2,4 and exec_en is 1 on cycles 1,3,5.
- Jump: at PC=5 in EXECUTE, jump=1 with jump_addr=0x3A0 → next cycle pc_out=0x3A0, fetch_en=1. The following EXECUTE shows pc_out=0x3A1.
- Halt/resume with simultaneous jump: in EXECUTE assert halt=1, jump=1, jump_addr=0x010 → halted=1, pc_out=0x010, both strobes 0. Hold for 4 cycles with jump=1 and no change. Then resume=1 → FETCH at 0x010.
- Wrap and freeze: preload PC=0xFFF via jump and run → after FETCH, pc_out=0x000. Drop enable for 3 cycles mid-EXECUTE → pc_out/state frozen and strobes 0. Re-enable and the same EXECUTE completes.
- Async reset mid-operation: assert reset=0 between edges while in EXECUTE at PC=0x123 → pc_out=RESET_PC, phase=0, exec_en=0 before the next clk edge.
